hilo_div_sequencer: RTL and testbench

//  Multi-cycle iterative divider plus HI/LO register file for DIV/DIVU/MTHI/MTLO.

---
 rtl/hilo_div_sequencer_if.sv | 30 +++
 rtl/hilo_div_sequencer.sv | 119 +++++++++++
 tb/tb_hilo_div_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hilo_div_sequencer_if.sv
// Issue/result bundle between the core and the HI/LO divide sequencer.
`timescale 1ns/1ps
interface hilo_div_sequencer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start;
    logic              unsigned_instr;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              mthi_we;
    logic              mtlo_we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;
    logic              div_by_zero;

    // Core side
    modport master (
        output start, unsigned_instr, dividend, divisor, mthi_we, mtlo_we, wdata,
        input  hi, lo, busy, done, div_by_zero
    );

    // Divider side
    modport slave (
        input  start, unsigned_instr, dividend, divisor, mthi_we, mtlo_we, wdata,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/hilo_div_sequencer.sv
// Multi-cycle restoring divider with the HI/LO register pair (DIV/DIVU/MTHI/MTLO).
// Fixed latency: one quotient bit per cycle plus operand prep and sign fix-up.
`timescale 1ns/1ps
module hilo_div_sequencer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hilo_div_sequencer_if.slave   bus
);
    localparam int unsigned        CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] rem_q, quo_q, dsr_q, hi_q, lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              uns_q, neg_a_q, neg_b_q, zero_q;
    logic              busy_q, done_q, dbz_q;
    logic              accept;
    logic [DATA_W:0]   shifted, trial;
    logic [DATA_W-1:0] fix_hi, fix_lo;

    assign accept = bus.start && (state_q == StIdle || state_q == StDone);

    // Shift in the next dividend bit; the extra top bit keeps large unsigned remainders exact.
    assign shifted = {rem_q, quo_q[DATA_W-1]};
    assign trial   = shifted - {1'b0, dsr_q};

    // Sign restoration: quotient negated on sign mismatch, remainder follows the dividend.
    assign fix_lo = zero_q ? '0 : ((neg_a_q ^ neg_b_q) ? -quo_q : quo_q);
    assign fix_hi = zero_q ? '0 : (neg_a_q ? -rem_q : rem_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StPrep;
            StPrep:  state_d = StIter;
            StIter:  if (cnt_q == CNT_LAST) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = accept ? StPrep : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath, HI/LO file and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            uns_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            busy_q <= state_d inside {StPrep, StIter, StFix};
            done_q <= (state_q == StFix);
            dbz_q  <= (state_q == StFix) && zero_q;

            // Moves are dropped while a division is in flight; FIX below overrides them.
            if (!busy_q) begin
                if (bus.mthi_we) hi_q <= bus.wdata;
                if (bus.mtlo_we) lo_q <= bus.wdata;
            end

            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        uns_q <= bus.unsigned_instr;
                        quo_q <= bus.dividend;
                        dsr_q <= bus.divisor;
                        rem_q <= '0;
                        cnt_q <= '0;
                    end
                end
                StPrep: begin
                    neg_a_q <= !uns_q && quo_q[DATA_W-1];
                    neg_b_q <= !uns_q && dsr_q[DATA_W-1];
                    quo_q   <= (!uns_q && quo_q[DATA_W-1]) ? -quo_q : quo_q;
                    dsr_q   <= (!uns_q && dsr_q[DATA_W-1]) ? -dsr_q : dsr_q;
                    zero_q  <= (dsr_q == '0);
                    rem_q   <= '0;
                    cnt_q   <= '0;
                end
                StIter: begin
                    quo_q <= {quo_q[DATA_W-2:0], ~trial[DATA_W]};
                    rem_q <= trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
                    if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
                end
                StFix: begin
                    hi_q <= fix_hi;
                    lo_q <= fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_hilo_div_sequencer.sv
// Directed bench for hilo_div_sequencer: signed/unsigned divides, corner cases,
// back-to-back issue, ignored mid-op requests, MTHI/MTLO and async reset abort.
`timescale 1ns/1ps
module tb_hilo_div_sequencer;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    hilo_div_sequencer_if #(.DATA_W(DATA_W)) bus ();

    hilo_div_sequencer #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a DIV/DIVU for exactly one edge; the divider must go busy on that edge.
    task automatic issue(input logic uns, input logic [31:0] a, input logic [31:0] b);
        bus.start          = 1'b1;
        bus.unsigned_instr = uns;
        bus.dividend       = a;
        bus.divisor        = b;
        tick();
        bus.start = 1'b0;
        check_eq("busy_after_start", {31'b0, bus.busy}, 32'd1);
        check_eq("done_after_start", {31'b0, bus.done}, 32'd0);
    endtask

    // Count edges since the issuing edge until done; expect 35.
    task automatic wait_done(input string tag, input int first, input logic [31:0] exp_lo,
                             input logic [31:0] exp_hi, input logic exp_dbz);
        int cnt = first;
        while (bus.done !== 1'b1 && cnt < 60) begin
            tick();
            cnt++;
        end
        check_eq({tag, "_latency"}, cnt, 32'd35);
        check_eq({tag, "_lo"}, bus.lo, exp_lo);
        check_eq({tag, "_hi"}, bus.hi, exp_hi);
        check_eq({tag, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, exp_dbz});
        check_eq({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst_n              = 1'b0;
        bus.start          = 1'b0;
        bus.unsigned_instr = 1'b0;
        bus.dividend       = '0;
        bus.divisor        = '0;
        bus.mthi_we        = 1'b0;
        bus.mtlo_we        = 1'b0;
        bus.wdata          = '0;
        #12;
        check_eq("rst_hi", bus.hi, 32'd0);
        check_eq("rst_lo", bus.lo, 32'd0);
        check_eq("rst_busy", {31'b0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'b0, bus.done}, 32'd0);
        check_eq("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // MTHI and MTLO in the same cycle, then MTHI alone
        bus.mthi_we = 1'b1;
        bus.mtlo_we = 1'b1;
        bus.wdata   = 32'h1234_5678;
        tick();
        bus.mtlo_we = 1'b0;
        bus.wdata   = 32'h0000_AAAA;
        check_eq("mt_both_hi", bus.hi, 32'h1234_5678);
        check_eq("mt_both_lo", bus.lo, 32'h1234_5678);
        tick();
        bus.mthi_we = 1'b0;
        check_eq("mthi_hi", bus.hi, 32'h0000_AAAA);
        check_eq("mthi_lo", bus.lo, 32'h1234_5678);

        // Back-to-back chain: each issue lands in the DONE cycle of the previous op
        issue(1'b1, 32'd100, 32'd7);
        wait_done("divu_100_7", 1, 32'd14, 32'd2, 1'b0);
        issue(1'b0, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        issue(1'b0, 32'd7, 32'hFFFF_FFFE);
        wait_done("div_7_m2", 1, 32'hFFFF_FFFD, 32'd1, 1'b0);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 1, 32'h8000_0000, 32'd0, 1'b0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divu_big", 1, 32'd0, 32'h8000_0000, 1'b0);
        issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
        wait_done("divu_wide_rem", 1, 32'd1, 32'h7FFF_FFFE, 1'b0);
        issue(1'b1, 32'd5, 32'd0);
        wait_done("divu_by0", 1, 32'd0, 32'd0, 1'b1);
        tick();
        check_eq("by0_dbz_pulse", {31'b0, bus.div_by_zero}, 32'd0);
        check_eq("by0_done_pulse", {31'b0, bus.done}, 32'd0);

        // MTHI with start in IDLE: move lands, result later overwrites it
        bus.mthi_we = 1'b1;
        bus.wdata   = 32'h0000_CAFE;
        issue(1'b1, 32'd100, 32'd7);
        bus.mthi_we = 1'b0;
        check_eq("mt_with_start_hi", bus.hi, 32'h0000_CAFE);
        repeat (5) tick();
        // Mid-op start and moves must be dropped
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd10;
        bus.mthi_we  = 1'b1;
        bus.mtlo_we  = 1'b1;
        bus.wdata    = 32'h0000_BEEF;
        tick();
        bus.start   = 1'b0;
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
        check_eq("midop_mthi_dropped", bus.hi, 32'h0000_CAFE);
        check_eq("midop_mtlo_dropped", bus.lo, 32'd0);
        wait_done("midop_ignored", 7, 32'd14, 32'd2, 1'b0);
        tick();

        // Reset abort during ITER
        bus.mthi_we = 1'b1;
        bus.mtlo_we = 1'b1;
        bus.wdata   = 32'h0000_5555;
        tick();
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
        check_eq("pre_rst_hi", bus.hi, 32'h0000_5555);
        issue(1'b1, 32'd100, 32'd7);
        repeat (11) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_hi", bus.hi, 32'd0);
        check_eq("abort_lo", bus.lo, 32'd0);
        check_eq("abort_busy", {31'b0, bus.busy}, 32'd0);
        check_eq("abort_done", {31'b0, bus.done}, 32'd0);
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        check_eq("abort_no_done", dones, 32'd0);
        check_eq("abort_idle_busy", {31'b0, bus.busy}, 32'd0);
        check_eq("abort_hi_kept", bus.hi, 32'd0);

        // Normal operation resumes after reset
        issue(1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        wait_done("div_m100_m7", 1, 32'd14, 32'hFFFF_FFFE, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
